ahb3lite_mem_slave: RTL
=======================

# ahb3lite_mem_slave

AHB-Lite word-addressed memory responder: the target end of the DMA write traffic generated by the CPU/DMA master. It decodes address phases (IDLE/BUSY/NONSEQ/SEQ), inserts a programmable number of wait states per transfer, and commits writes to an internal word array. It also serves reads and returns the two-cycle ERROR response for illegal accesses. Status counters feed the verifier for end-of-burst checking.

## Interface
Parameters:
- ADDR_W, 6: log2 of memory depth in 32-bit words (64 words).
- BASE_ADDR, 32'h0000_0000: first word address decoded by the slave.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted per accepted transfer (0..15).

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- HSEL  in  1  slave select.
- HADDR  in  32  word address; the master increments by 1 per beat.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  transfer size; only WORD is legal.
- HBURST  in  HBURST_Type  burst type (ahb3lite_pkg); informational, no decode effect.
- HTRANS  in  HTRANS_state  IDLE/BUSY/NONSEQ/SEQ.
- HWDATA  in  32  write data, valid in data phase.
- HREADY  in  1  bus-level ready; address phase accepted only when high.
- HREADYOUT  out  1  slave ready.
- HRESP  out  HRESP_state  OKAY/ERROR.
- HRDATA  out  32  read data.
- o_wr_count  out  16  committed writes since reset (wraps).
- o_err_count  out  8  ERROR responses since reset (saturates at 255).
- o_last_addr  out  32  address of most recent committed write.
- o_last_data  out  32  data of most recent committed write.

## Operation
- Accept: address phase sampled when HSEL & HREADY & HTRANS ∈ {NONSEQ, SEQ}; capture HADDR, HWRITE, HSIZE.
- Not accepted (IDLE, BUSY, HSEL=0): no access; the following cycle is a zero-wait OKAY (HREADYOUT=1).
- Legality: offset = HADDR − BASE_ADDR; legal iff offset < 2**ADDR_W (unsigned, 32-bit subtract) and HSIZE == WORD. Illegal → ERROR sequence; no memory access and no counter update except o_err_count.
- FSM states:
  - READY: HREADYOUT=1, HRESP=OKAY. On a legal accept: go to WAIT if WAIT_STATES>0, else DATA. On an illegal accept: go to ERR1.
  - WAIT: HREADYOUT=0; the counter runs WAIT_STATES cycles, then the FSM goes to DATA.
  - DATA: HREADYOUT=1, OKAY. At this edge, a write commits mem[offset] ← HWDATA and updates o_wr_count, o_last_addr and o_last_data. A read drives HRDATA = mem[offset] during this cycle. A new accept in the same cycle is evaluated exactly as in READY (pipelined back-to-back). With no new accept, the FSM returns to READY.
  - ERR1: HREADYOUT=0, HRESP=ERROR → ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR; an accept here is evaluated as in READY.
- Address phases presented while HREADYOUT=0 are ignored (HREADY is low).
- HRDATA holds its last value outside read data phases.

## Timing
- Reset (HRESET=1 at an edge): FSM=READY, HREADYOUT=1, HRESP=OKAY, HRDATA=0, all o_* = 0, wait counter=0. Memory contents are retained.
- Reset mid-transfer aborts it. A pending write is not committed, and the next cycle is READY.
- Transfer latency: the data phase is WAIT_STATES+1 cycles after the address-phase edge. A zero-wait burst of N beats completes in N+1 cycles.
- Read-after-write to the same address in consecutive beats returns the new data. The write commits at the end of its data phase, before the read's data phase.
- BUSY between beats inserts no wait and performs no access. The next SEQ beat is accepted normally.
- ERROR always takes exactly 2 cycles, independent of WAIT_STATES.

## Test plan
- Reset, then WAIT_STATES=0, INCR4 write from 0x10, data 0xA0..0xA3 → mem[0x10..0x13]=0xA0..0xA3, HREADYOUT constantly 1, o_wr_count=4, o_last_addr=0x13, o_last_data=0xA3.
- WAIT_STATES=2, SINGLE write 0x5 → 0xDEADBEEF → HREADYOUT low exactly 2 cycles, then 1; a read of 0x5 returns 0xDEADBEEF.
- INCR8 write with 3 BUSY cycles inserted after beat 2 → all 8 words written, o_wr_count +8, no ERROR, no extra wait.
- NONSEQ write to BASE_ADDR+64 (out of range) → ERR1 (HREADYOUT=0, ERROR), then ERR2 (HREADYOUT=1, ERROR); memory unchanged, o_err_count=1. The same check with HSIZE=HALFWORD gives the same response.
- Write 0x77 to 0x3, immediately followed by a read of 0x3 → HRDATA=0x77 in the read data phase.
- HRESET asserted during WAIT of a write to 0x8 (old value 0x11) → next cycle HREADYOUT=1, o_wr_count=0, mem[0x8]=0x11.

Source files
------------

// File: rtl/ahb3lite_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg / ahb3lite_mem_slave
//
// Purpose: AHB-Lite word-addressed memory target. Decodes IDLE/BUSY/NONSEQ/SEQ
// address phases, inserts WAIT_STATES HREADYOUT-low cycles per accepted
// transfer, commits writes to an internal word array, serves reads and
// returns the two-cycle ERROR response for out-of-range or non-word accesses.
// Status counters report committed writes and ERROR responses.
//
// Ports:
//   HCLK        in   bus clock, rising edge
//   HRESET      in   synchronous active-high reset
//   HSEL        in   slave select
//   HADDR       in   word address (32)
//   HWRITE      in   1 = write, 0 = read
//   HSIZE       in   transfer size, only WORD (3'b010) is legal
//   HBURST      in   burst type, informational only
//   HTRANS      in   IDLE/BUSY/NONSEQ/SEQ
//   HWDATA      in   write data (data phase)
//   HREADY      in   bus-level ready
//   HREADYOUT   out  slave ready
//   HRESP       out  OKAY/ERROR
//   HRDATA      out  read data (held outside read data phases)
//   o_wr_count  out  committed writes since reset, wraps (16)
//   o_err_count out  ERROR responses since reset, saturates (8)
//   o_last_addr out  address of most recent committed write (32)
//   o_last_data out  data of most recent committed write (32)
// ---------------------------------------------------------------------------
package ahb3lite_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_state;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } HBURST_Type;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } HRESP_state;

  localparam logic [2:0] HSIZE_WORD = 3'b010;
endpackage

module ahb3lite_mem_slave
  import ahb3lite_pkg::*;
#(
  parameter int          ADDR_W      = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  HBURST_Type  HBURST,
  input  HTRANS_state HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output HRESP_state  HRESP,
  output logic [31:0] HRDATA,
  output logic [15:0] o_wr_count,
  output logic [7:0]  o_err_count,
  output logic [31:0] o_last_addr,
  output logic [31:0] o_last_data
);

  typedef enum logic [2:0] {
    ST_READY = 3'd0,
    ST_WAIT  = 3'd1,
    ST_DATA  = 3'd2,
    ST_ERR1  = 3'd3,
    ST_ERR2  = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_wait_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_full_addr;
  logic               r_write;
  logic [31:0]        r_hrdata;
  logic [15:0]        r_wr_count;
  logic [7:0]         r_err_count;
  logic [31:0]        r_last_addr;
  logic [31:0]        r_last_data;
  logic [31:0]        r_mem [2**ADDR_W];

  logic               w_slot_open;
  logic               w_accept;
  logic [31:0]        w_offset;
  logic               w_legal;
  logic               w_commit;
  logic               w_rd_phase;
  logic               w_unused;

  // HBURST carries no decode meaning for a flat memory.
  assign w_unused = ^HBURST;

  // Only states that drive HREADYOUT high can take a new address phase.
  assign w_slot_open = (r_state == ST_READY) || (r_state == ST_DATA) ||
                       (r_state == ST_ERR2);
  assign w_accept    = w_slot_open && HSEL && HREADY &&
                       ((HTRANS == NONSEQ) || (HTRANS == SEQ));

  // Unsigned subtract: addresses below BASE_ADDR wrap high and fail the range test.
  assign w_offset    = HADDR - BASE_ADDR;
  assign w_legal     = ((w_offset >> ADDR_W) == 32'd0) && (HSIZE == HSIZE_WORD);

  assign w_commit    = (r_state == ST_DATA) && r_write;
  assign w_rd_phase  = (r_state == ST_DATA) && !r_write;

  always_comb begin
    w_next    = r_state;
    HREADYOUT = 1'b1;
    HRESP     = OKAY;
    case (r_state)
      ST_READY, ST_DATA, ST_ERR2: begin
        if (r_state == ST_ERR2) HRESP = ERROR;
        if (w_accept) begin
          if (!w_legal)             w_next = ST_ERR1;
          else if (WAIT_STATES > 0) w_next = ST_WAIT;
          else                      w_next = ST_DATA;
        end else begin
          w_next = ST_READY;
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (r_wait_cnt == WAIT_LAST) w_next = ST_DATA;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = ERROR;
        w_next    = ST_ERR2;
      end
      default: w_next = ST_READY;
    endcase
  end

  // Control state, counters and status outputs
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_READY;
      r_wait_cnt  <= 4'd0;
      r_hrdata    <= 32'd0;
      r_wr_count  <= 16'd0;
      r_err_count <= 8'd0;
      r_last_addr <= 32'd0;
      r_last_data <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_next == ST_WAIT)
        r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 4'd1 : 4'd0;
      else
        r_wait_cnt <= 4'd0;
      if (w_accept && !w_legal && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
      if (w_commit) begin
        r_wr_count  <= r_wr_count + 16'd1;
        r_last_addr <= r_full_addr;
        r_last_data <= HWDATA;
      end
      if (w_rd_phase)
        r_hrdata <= r_mem[r_addr];
    end
  end

  // Address-phase capture
  always_ff @(posedge HCLK) begin
    if (w_accept) begin
      r_addr      <= w_offset[ADDR_W-1:0];
      r_full_addr <= HADDR;
      r_write     <= HWRITE;
    end
  end

  // Memory array; contents survive reset, a reset edge blocks the commit.
  always_ff @(posedge HCLK) begin
    if (!HRESET && w_commit)
      r_mem[r_addr] <= HWDATA;
  end

  // Read data is live from the array during the read data phase so that a
  // write committed on the previous edge is visible.
  assign HRDATA      = w_rd_phase ? r_mem[r_addr] : r_hrdata;
  assign o_wr_count  = r_wr_count;
  assign o_err_count = r_err_count;
  assign o_last_addr = r_last_addr;
  assign o_last_data = r_last_data;

endmodule
